// File: rtl/bus_fifo_pkg.sv
// rtl/bus_fifo_pkg.sv - shared constants and sizing helpers for the bus driver FIFO
package bus_fifo_pkg;

  localparam int ID_W        = 8;
  localparam int PCKG_SZ_DEF = 16;
  localparam int DEPTH_DEF   = 8;

  // Occupancy must represent 0..depth inclusive, hence depth+1 states.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/bus_fifo_ptr.sv
// rtl/bus_fifo_ptr.sv - wrapping pointer counter, 0..depth-1, for any depth
module bus_fifo_ptr import bus_fifo_pkg::*; #(
  parameter int depth = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     inc,
  output logic [$clog2(depth)-1:0] ptr
);

  localparam int            PW   = $clog2(depth);
  localparam logic [PW-1:0] LAST = PW'(depth - 1);

  // Explicit wrap so non-power-of-two depths never index past the array.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + PW'(1);
    end
  end

endmodule

// File: rtl/bus_drvr_fifo.sv
// rtl/bus_drvr_fifo.sv - FWFT bus driver FIFO; BUS_FIFO_OVWR_OLDEST_EN selects overwrite-oldest on overflow
module bus_drvr_fifo import bus_fifo_pkg::*; #(
  parameter int pckg_sz = PCKG_SZ_DEF,
  parameter int depth   = DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [pckg_sz-1:0]        D_push,
  output logic                      full,
  output logic                      pndng,
  input  logic                      pop,
  output logic [pckg_sz-1:0]        D_pop,
  output logic [cnt_w(depth)-1:0]   count,
  output logic                      ovf
);

  localparam int CW = cnt_w(depth);
  localparam int PW = $clog2(depth);

  logic [pckg_sz-1:0] mem [depth];
  logic [PW-1:0]      rd_ptr;
  logic [PW-1:0]      wr_ptr;
  logic               do_pop;
  logic               ovf_push;
  logic               wr_en;
  logic               rd_inc;

  always_comb begin
    do_pop   = pop & pndng;
    ovf_push = push & full & ~do_pop;
`ifdef BUS_FIFO_OVWR_OLDEST_EN
    // When full, wr_ptr == rd_ptr, so the write lands on the oldest slot.
    wr_en    = push;
    rd_inc   = do_pop | ovf_push;
`else
    wr_en    = push & ~ovf_push;
    rd_inc   = do_pop;
`endif
  end

  bus_fifo_ptr #(.depth(depth)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (wr_en),
    .ptr   (wr_ptr)
  );

  bus_fifo_ptr #(.depth(depth)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (rd_inc),
    .ptr   (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= D_push;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (wr_en && !rd_inc) begin
        count <= count + CW'(1);
      end else if (!wr_en && rd_inc) begin
        count <= count - CW'(1);
      end
      if (ovf_push) begin
        ovf <= 1'b1;
      end
    end
  end

  // Flags decode only the registered count, so they never see push/pop directly.
  assign full  = (count == CW'(depth));
  assign pndng = (count != '0);
  assign D_pop = pndng ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_bus_drvr_fifo.sv
// tb/tb_bus_drvr_fifo.sv - scoreboard bench for bus_drvr_fifo at depth 8 and depth 5
module tb_bus_drvr_fifo;

  localparam int W = 16;

  typedef struct {
    bit          pndng;
    bit          full;
    bit          ovf;
    int          count;
    logic [W-1:0] d;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         push = 1'b0;
  logic         pop = 1'b0;
  logic [W-1:0] d_push = '0;

  logic         full8, pndng8, ovf8;
  logic [W-1:0] dpop8;
  logic [3:0]   count8;
  logic         full5, pndng5, ovf5;
  logic [W-1:0] dpop5;
  logic [2:0]   count5;

  logic [W-1:0] mq [2][$];
  bit           movf [2];
  exp_t         eq [2][$];
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  bus_drvr_fifo #(.pckg_sz(W), .depth(8)) u8 (
    .clk(clk), .reset(reset), .push(push), .D_push(d_push), .full(full8),
    .pndng(pndng8), .pop(pop), .D_pop(dpop8), .count(count8), .ovf(ovf8)
  );

  bus_drvr_fifo #(.pckg_sz(W), .depth(5)) u5 (
    .clk(clk), .reset(reset), .push(push), .D_push(d_push), .full(full5),
    .pndng(pndng5), .pop(pop), .D_pop(dpop5), .count(count5), .ovf(ovf5)
  );

  function automatic int dep_of(input int k);
    return (k == 0) ? 8 : 5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a queue per FIFO; pop happens before push in the same cycle.
  task automatic step(input bit p, input bit q, input logic [W-1:0] d);
    @(negedge clk);
    push = p;
    pop = q;
    d_push = d;
    for (int k = 0; k < 2; k++) begin
      bit   dp;
      exp_t e;
      dp = q && (mq[k].size() > 0);
      if (p) begin
        if (mq[k].size() < dep_of(k) || dp) begin
          if (dp) void'(mq[k].pop_front());
          mq[k].push_back(d);
        end else begin
          movf[k] = 1'b1;
`ifdef BUS_FIFO_OVWR_OLDEST_EN
          void'(mq[k].pop_front());
          mq[k].push_back(d);
`endif
        end
      end else if (dp) begin
        void'(mq[k].pop_front());
      end
      e.count = mq[k].size();
      e.full  = (mq[k].size() == dep_of(k));
      e.pndng = (mq[k].size() > 0);
      e.d     = (mq[k].size() > 0) ? mq[k][0] : '0;
      e.ovf   = movf[k];
      eq[k].push_back(e);
    end
  endtask

  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      if (eq[k].size() > 0) begin
        exp_t e;
        string s;
        e = eq[k].pop_front();
        s = (k == 0) ? "d8" : "d5";
        chk({s, "_count"}, (k == 0) ? 32'(count8) : 32'(count5), 32'(e.count));
        chk({s, "_full"},  (k == 0) ? 32'(full8)  : 32'(full5),  32'(e.full));
        chk({s, "_pndng"}, (k == 0) ? 32'(pndng8) : 32'(pndng5), 32'(e.pndng));
        chk({s, "_ovf"},   (k == 0) ? 32'(ovf8)   : 32'(ovf5),   32'(e.ovf));
        chk({s, "_dpop"},  (k == 0) ? 32'(dpop8)  : 32'(dpop5),  32'(e.d));
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_d8_count"}, 32'(count8), 32'd0);
    chk({tag, "_d8_full"},  32'(full8),  32'd0);
    chk({tag, "_d8_pndng"}, 32'(pndng8), 32'd0);
    chk({tag, "_d8_dpop"},  32'(dpop8),  32'd0);
    chk({tag, "_d8_ovf"},   32'(ovf8),   32'd0);
    chk({tag, "_d5_count"}, 32'(count5), 32'd0);
    chk({tag, "_d5_pndng"}, 32'(pndng5), 32'd0);
    chk({tag, "_d5_dpop"},  32'(dpop5),  32'd0);
    chk({tag, "_d5_ovf"},   32'(ovf5),   32'd0);
  endtask

  // Assert between edges after the monitor has consumed the pending expectation.
  task automatic do_reset(input string tag);
    @(posedge clk);
    #3;
    push = 1'b0;
    pop = 1'b0;
    reset = 1'b0;
    #1;
    check_zero(tag);
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      movf[k] = 1'b0;
    end
    @(negedge clk);
    #2;
    reset = 1'b1;
  endtask

  initial begin
    #1;
    check_zero("por");
    #11;
    reset = 1'b1;

    step(1'b1, 1'b0, 16'h0AAA);
    step(1'b1, 1'b0, 16'h0BBB);
    step(1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b1, 16'h0);
    step(1'b0, 1'b0, 16'h0);

    do_reset("rst1");
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 16'(16'h0100 + i));
    step(1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b1, 16'hBEEF);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 16'h0);

    do_reset("rst2");
    step(1'b0, 1'b1, 16'h0);
    step(1'b1, 1'b1, 16'h5A5A);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 16'($urandom));
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 16'($urandom));
      step(1'b0, 1'b1, 16'h0);
    end

    for (int i = 0; i < 400; i++) begin
      int bias;
      bias = (i < 130) ? 75 : (i < 260) ? 25 : 50;
      step($urandom_range(0, 99) < bias, $urandom_range(0, 99) < (100 - bias), 16'($urandom));
    end

    do_reset("rst3");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'($urandom));
    do_reset("mid");
    step(1'b1, 1'b0, 16'h1234);
    step(1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b1, 16'h0);
    step(1'b0, 1'b0, 16'h0);

    @(posedge clk);
    #3;
    chk("drain_d8", 32'(eq[0].size()), 32'd0);
    chk("drain_d5", 32'(eq[1].size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_drvr_fifo.md
BUS_DRVR_FIFO -- requirements
Module: bus_drvr_fifo

Interface
REQ-001 Parameter pckg_sz, default 16, packet width in bits; the top 8 bits are the destination ID and are carried unmodified.
REQ-002 Parameter depth, default 8, FIFO capacity in packets; legal range 2..256, any integer, not only powers of two.
REQ-003 Port clk  input  1  single clock; all state updates on posedge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port push  input  1  agent/driver write request.
REQ-006 Port D_push  input  pckg_sz  packet written on push.
REQ-007 Port full  output  1  high when count equals depth.
REQ-008 Port pndng  output  1  high when count is nonzero; feeds the bus generator/arbiter pndng input.
REQ-009 Port pop  input  1  read acknowledge from the bus generator/arbiter.
REQ-010 Port D_pop  output  pckg_sz  head packet, first-word-fall-through.
REQ-011 Port count  output  $clog2(depth+1)  current occupancy.
REQ-012 Port ovf  output  1  sticky overflow flag.

Function
REQ-013 D_pop shall present mem[rd_ptr] whenever pndng=1 and shall be all-zero when pndng=0.
REQ-014 A pop with pndng=1 shall advance rd_ptr at the clock edge; D_pop shows the next packet in the following cycle.
REQ-015 A pop with pndng=0 shall be ignored, with no pointer, count or flag change.
REQ-016 A push with full=0 shall write D_push at wr_ptr and advance wr_ptr; the data appears on D_pop no earlier than the next cycle.
REQ-017 Pointers shall wrap from depth-1 to 0.
REQ-018 Simultaneous push and valid pop with 0<count<depth: both execute and count is unchanged.
REQ-019 Simultaneous push and valid pop at count=depth: both execute, count stays depth, and ovf is not set.
REQ-020 Push and pop at count=0: only the push executes; count becomes 1.
REQ-021 A push with full=1 and no pop is an overflow; handling is per REQ-027/028, and ovf shall set and remain set until reset.
REQ-022 count, full and pndng shall be registered-consistent, i.e. derived from the same post-edge state, with no combinational path from push or pop.

Reset
REQ-023 Asserting reset shall immediately force rd_ptr=0, wr_ptr=0, count=0, full=0, pndng=0, D_pop=0 and ovf=0.
REQ-024 Memory contents are not reset.
REQ-025 Reset asserted mid-transfer shall discard all stored packets; the first push after deassertion lands at index 0.
REQ-026 Reset deassertion is synchronised by the integrator; the block only requires that reset is released away from clk edges.

Configuration
REQ-027 Macro BUS_FIFO_OVWR_OLDEST_EN defined: an overflow push shall overwrite the oldest packet. Both pointers advance, count stays depth, and D_pop shows the second-oldest packet next cycle.
REQ-028 Macro BUS_FIFO_OVWR_OLDEST_EN undefined: an overflow push shall be dropped, leaving FIFO contents and pointers unchanged.

Structure
REQ-029 Package bus_fifo_pkg shall hold ID_W=8, the default pckg_sz and depth constants, and a function returning the count width.
REQ-030 Sub-module bus_fifo_ptr is the wrapping pointer counter (inputs: inc, clk, reset; parameter depth), instantiated twice.
REQ-031 Storage is a plain register array; no vendor RAM is used.

Verification
REQ-032 Reset, push 0x0AAA then 0x0BBB, no pop -> pndng=1, D_pop=0x0AAA, count=2; then one pop -> D_pop=0x0BBB, count=1.
REQ-033 depth=8: push 8 packets -> full=1, count=8; a 9th push with macro off -> ovf=1 and D_pop still the first packet; with macro on -> D_pop equals the second packet.
REQ-034 count=8: push+pop in the same cycle -> count=8, ovf=0, and the new packet is read last.
REQ-035 Empty FIFO: pop alone -> no change; push+pop together -> count=1, D_pop equals the pushed data.
REQ-036 depth=5: run 12 push/pop pairs -> pointers wrap and data order is preserved.
REQ-037 Assert reset at count=3 between edges -> outputs zero immediately; after release, push 0x1234 -> D_pop=0x1234.
